// File: rtl/sumador_serial_ctrl_pkg.sv
// rtl/sumador_serial_ctrl_pkg.sv - shared types and defaults for the bit-serial adder controller
package sumador_serial_ctrl_pkg;

    // Controller states; encodings are fixed so they match existing power-analysis scripts
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_PWRC  = 0;

    // Reference sum of the serial datapath: {carry_out, sum} of a + b + ci
    function automatic logic [DEF_WIDTH:0] ref_add(input logic [DEF_WIDTH-1:0] a,
                                                   input logic [DEF_WIDTH-1:0] b,
                                                   input logic                 ci);
        return (DEF_WIDTH+1)'(a) + (DEF_WIDTH+1)'(b) + (DEF_WIDTH+1)'(ci);
    endfunction

endpackage

// File: rtl/sumador_serial_ctrl_if.sv
// rtl/sumador_serial_ctrl_if.sv - operand/result handshake bundle for the serial adder
interface sumador_serial_ctrl_if
    import sumador_serial_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    // Producer/consumer side
    modport master (
        output in_valid, op_a, op_b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out
    );

    // Controller side
    modport slave (
        input  in_valid, op_a, op_b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out
    );
endinterface

// File: rtl/sumador_serial_ctrl_sumador_completo.sv
// rtl/sumador_serial_ctrl_sumador_completo.sv - one-bit full adder driven by the serial controller
module sumador_completo #(
    parameter int PwrC = 0
) (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    // PwrC is a power-characterisation tag; negative values are meaningless
    if (PwrC < 0) begin : g_bad_pwrc
        $error("sumador_completo: PwrC must be non-negative");
    end

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/sumador_serial_ctrl.sv
// rtl/sumador_serial_ctrl.sv - bit-serial adder controller with sum-bit toggle counter
module sumador_serial_ctrl
    import sumador_serial_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int PwrC  = DEF_PWRC
) (
    input  logic                  clk,
    input  logic                  reset_L,
    sumador_serial_ctrl_if.slave  bus,
    output logic                  busy,
    input  logic                  clr_cnt,
    output logic [CNT_W-1:0]      toggle_cnt
);
    localparam int IDX_W = $clog2(WIDTH);

    if (WIDTH < 2) begin : g_bad_width
        $error("sumador_serial_ctrl: WIDTH must be at least 2");
    end

    state_e             state_q;
    logic [WIDTH-1:0]   a_sr_q;
    logic [WIDTH-1:0]   b_sr_q;
    // Upper WIDTH-1 bits of the sum shift register; bit 0 is never read again
    logic [WIDTH-2:0]   s_hi_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic               c_out_q;
    logic [IDX_W-1:0]   bit_idx_q;
    logic [CNT_W-1:0]   toggle_cnt_q;
    logic [CNT_W-1:0]   toggle_cnt_d;
    logic               last_s_q;
    logic               last_s_d;
    logic               add_s;
    logic               add_co;
    logic [WIDTH-1:0]   sum_shift;

    sumador_completo #(
        .PwrC (PwrC)
    ) u_fa (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (carry_q),
        .s  (add_s),
        .co (add_co)
    );

    // New sum bit enters at the top; after the last bit this is the full result
    assign sum_shift = {add_s, s_hi_q};

    // Control FSM with operand/sum shift registers and the carry flop
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= ST_IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            s_hi_q    <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            c_out_q   <= 1'b0;
            bit_idx_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_sr_q    <= bus.op_a;
                        b_sr_q    <= bus.op_b;
                        carry_q   <= bus.c_in;
                        bit_idx_q <= '0;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    s_hi_q    <= sum_shift[WIDTH-1:1];
                    carry_q   <= add_co;
                    a_sr_q    <= a_sr_q >> 1;
                    b_sr_q    <= b_sr_q >> 1;
                    bit_idx_q <= bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == IDX_W'(WIDTH - 1)) begin
                        sum_q   <= sum_shift;
                        c_out_q <= add_co;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Toggle counter next state: saturating count of sum-bit changes, clear wins
    always_comb begin
        toggle_cnt_d = toggle_cnt_q;
        last_s_d     = last_s_q;
        if (state_q == ST_SHIFT) begin
            last_s_d = add_s;
            if ((add_s != last_s_q) && (toggle_cnt_q != '1)) begin
                toggle_cnt_d = toggle_cnt_q + CNT_W'(1);
            end
        end
        if (clr_cnt) begin
            toggle_cnt_d = '0;
        end
    end

    // Toggle counter and last sum bit registers; last_s persists across operations
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            toggle_cnt_q <= '0;
            last_s_q     <= 1'b0;
        end else begin
            toggle_cnt_q <= toggle_cnt_d;
            last_s_q     <= last_s_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign busy          = (state_q == ST_SHIFT);
    assign toggle_cnt    = toggle_cnt_q;
endmodule

// File: tb/tb_sumador_serial_ctrl.sv
// tb/tb_sumador_serial_ctrl.sv - self-checking bench for sumador_serial_ctrl
module tb_sumador_serial_ctrl;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        reset_L;
    logic        clr_cnt;
    logic        busy8, busy4;
    logic [15:0] tcnt8;
    logic [3:0]  tcnt4;

    sumador_serial_ctrl_if #(.WIDTH(W)) bus8 ();
    sumador_serial_ctrl_if #(.WIDTH(W)) bus4 ();

    sumador_serial_ctrl #(.WIDTH(W), .CNT_W(16), .PwrC(0)) dut8 (
        .clk        (clk),
        .reset_L    (reset_L),
        .bus        (bus8),
        .busy       (busy8),
        .clr_cnt    (clr_cnt),
        .toggle_cnt (tcnt8)
    );

    sumador_serial_ctrl #(.WIDTH(W), .CNT_W(4), .PwrC(0)) dut4 (
        .clk        (clk),
        .reset_L    (reset_L),
        .bus        (bus4),
        .busy       (busy4),
        .clr_cnt    (clr_cnt),
        .toggle_cnt (tcnt4)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   model_cnt;
    logic model_last;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic rdy);
        bus8.in_valid = v;  bus4.in_valid = v;
        bus8.op_a = a;      bus4.op_a = a;
        bus8.op_b = b;      bus4.op_b = b;
        bus8.c_in = ci;     bus4.c_in = ci;
        bus8.out_ready = rdy; bus4.out_ready = rdy;
    endtask

    // Model: the sum bits come out LSB first; count changes against the previous bit seen
    task automatic model_toggle(input logic [7:0] a, input logic [7:0] b, input logic ci);
        logic [8:0] r;
        r = 9'(a) + 9'(b) + 9'(ci);
        for (int i = 0; i < W; i++) begin
            if (r[i] != model_last) model_cnt++;
            model_last = r[i];
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_tcnt16"}, 32'(tcnt8), (model_cnt > 65535) ? 32'd65535 : 32'(model_cnt));
        check({tag, "_tcnt4"},  32'(tcnt4), (model_cnt > 15) ? 32'd15 : 32'(model_cnt));
    endtask

    task automatic model_reset();
        model_cnt  = 0;
        model_last = 1'b0;
    endtask

    // Starts at a negedge with both controllers idle; optionally releases the result
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic [7:0] exp_sum, input logic exp_cout, input bit rel);
        int edges;
        int busy_n;
        check("in_ready_idle", 32'(bus8.in_ready), 32'd1);
        drive(1'b1, a, b, ci, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        edges  = 0;
        busy_n = 0;
        while (!bus8.out_valid && edges < 40) begin
            if (busy8) busy_n++;
            @(negedge clk);
            edges++;
        end
        check("latency", 32'(edges), 32'(W));
        check("busy_cycles", 32'(busy_n), 32'(W));
        check("busy_in_done", 32'(busy8), 32'd0);
        check("in_ready_done", 32'(bus8.in_ready), 32'd0);
        check("sum16", 32'(bus8.sum), 32'(exp_sum));
        check("cout16", 32'(bus8.c_out), 32'(exp_cout));
        check("sum4", 32'(bus4.sum), 32'(exp_sum));
        check("valid4", 32'(bus4.out_valid), 32'd1);
        model_toggle(a, b, ci);
        check_counts("op");
        if (rel) begin
            drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            @(negedge clk);
            drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            check("valid_after_release", 32'(bus8.out_valid), 32'd0);
            check("ready_after_release", 32'(bus8.in_ready), 32'd1);
            check("sum_held_idle", 32'(bus8.sum), 32'(exp_sum));
        end
    endtask

    task automatic pulse_clr();
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] rr;
        int         bad;
        int         guard;

        vecs[0] = '{a: 8'h3C, b: 8'h15, ci: 1'b0, sum: 8'h51, cout: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, ci: 1'b0, sum: 8'h00, cout: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, ci: 1'b1, sum: 8'hFF, cout: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'h00, ci: 1'b1, sum: 8'h01, cout: 1'b0};
        vecs[4] = '{a: 8'h10, b: 8'h20, ci: 1'b0, sum: 8'h30, cout: 1'b0};
        vecs[5] = '{a: 8'h80, b: 8'h80, ci: 1'b1, sum: 8'h01, cout: 1'b1};

        reset_L = 1'b0;
        clr_cnt = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_sum", 32'(bus8.sum), 32'd0);
        check("rst_cout", 32'(bus8.c_out), 32'd0);
        check("rst_tcnt", 32'(tcnt8), 32'd0);
        reset_L = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus8.in_ready), 32'd1);

        // Toggle count of 0xAA from a zero last bit: 7 transitions
        pulse_clr();
        model_reset();
        run_op(8'hAA, 8'h00, 1'b0, 8'hAA, 1'b0, 1'b1);
        check("toggle_aa", 32'(tcnt8), 32'd7);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sum, vecs[i].cout, 1'b1);
        end

        for (int i = 0; i < 25; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rr = 9'(ra) + 9'(rb) + 9'(rc);
            run_op(ra, rb, rc, rr[7:0], rr[8], 1'b1);
        end

        // Backpressure: result held, new operands dropped
        run_op(8'h3C, 8'h15, 1'b0, 8'h51, 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'h55, 8'h66, 1'b1, 1'b0);
            @(negedge clk);
            if (!bus8.out_valid || bus8.in_ready || bus8.sum !== 8'h51 || bus8.c_out !== 1'b0 || busy8)
                bad++;
        end
        check("backpressure_hold", 32'(bad), 32'd0);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("bp_release_valid", 32'(bus8.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus8.in_ready), 32'd1);
        @(negedge clk);
        check("bp_dropped_busy", 32'(busy8), 32'd0);
        check_counts("bp");

        // Reset with bit_idx at 4
        drive(1'b1, 8'hC3, 8'h5A, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("midop_busy_before", 32'(busy8), 32'd1);
        reset_L = 1'b0;
        #1;
        check("midop_rst_busy", 32'(busy8), 32'd0);
        check("midop_rst_ready", 32'(bus8.in_ready), 32'd1);
        check("midop_rst_sum", 32'(bus8.sum), 32'd0);
        check("midop_rst_tcnt", 32'(tcnt8), 32'd0);
        @(negedge clk);
        reset_L = 1'b1;
        model_reset();
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.out_valid || busy8) bad++;
        end
        check("midop_no_valid", 32'(bad), 32'd0);
        run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b1);

        // Saturation of the 4-bit counter, then clear
        pulse_clr();
        model_cnt = 0;
        guard = 0;
        while (model_cnt < 20 && guard < 40) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rr = 9'(ra) + 9'(rb) + 9'(rc);
            run_op(ra, rb, rc, rr[7:0], rr[8], 1'b1);
            guard++;
        end
        check("sat_reached", 32'(model_cnt >= 20), 32'd1);
        check("tcnt4_saturated", 32'(tcnt4), 32'hF);
        pulse_clr();
        check("clr_tcnt16", 32'(tcnt8), 32'd0);
        check("clr_tcnt4", 32'(tcnt4), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
